// File: rtl/pwm_multi_core.sv
// APB4-controlled multi-channel PWM with shared edge/center-aligned counter and period interrupt.
// Define PWM_SHADOW_EN to preload CMP/CRx and apply them at period boundaries.
module pwm_multi_core #(
    parameter int unsigned CHN_NUM    = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned PSCR_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         paddr,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic [CHN_NUM-1:0] pwm_o,
    output logic               irq_o
);
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [4:0] IDX_CTRL = 5'd0;
    localparam logic [4:0] IDX_PSCR = 5'd1;
    localparam logic [4:0] IDX_CMP  = 5'd2;
    localparam logic [4:0] IDX_STAT = 5'd3;
    localparam logic [4:0] IDX_POL  = 5'd4;
    localparam logic [4:0] IDX_CR0  = 5'd8;

    logic [4:0]            idx;
    logic                  wr_en;
    logic                  rd_en;
    logic                  ovie;
    logic                  en;
    logic                  mode;
    logic                  ovif;
    logic [PSCR_WIDTH-1:0] pscr;
    logic [PSCR_WIDTH-1:0] psc;
    logic [CHN_NUM-1:0]    pol;
    logic [CHN_NUM-1:0]    active;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic [CNT_WIDTH-1:0]  cmp_reg;
    logic [CNT_WIDTH-1:0]  cmp_act;
    logic [CNT_WIDTH-1:0]  cr_reg [CHN_NUM];
    logic [CNT_WIDTH-1:0]  cr_act [CHN_NUM];
    dir_t                  dir;
    dir_t                  dir_nxt;
    logic                  clr;
    logic                  stat_clr;
    logic                  tick;
    logic                  period_evt;
    logic                  unused_bits;

    assign idx         = paddr[6:2];
    assign wr_en       = psel & penable & pwrite;
    assign rd_en       = psel & penable & ~pwrite;
    assign pready      = 1'b1;
    assign pslverr     = 1'b0;
    assign irq_o       = ovif;
    assign unused_bits = ^{paddr[7], paddr[1:0], pwdata};

    assign clr      = wr_en && (idx == IDX_CTRL) && pwdata[2];
    assign stat_clr = wr_en && (idx == IDX_STAT) && pwdata[0];
    assign tick     = en && (psc >= pscr);

    // Out-of-range counts (after CMP shrinks) wrap in edge mode and descend in center mode.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (cmp_act == '0) begin
            cnt_nxt = '0;
        end else if (!mode) begin
            cnt_nxt = (cnt >= cmp_act - 1'b1) ? '0 : cnt + 1'b1;
        end else if (dir == DIR_UP) begin
            if (cnt >= cmp_act) begin
                cnt_nxt = cnt - 1'b1;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            if (cnt == '0) begin
                cnt_nxt = cnt + 1'b1;
                dir_nxt = DIR_UP;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
        if (cnt_nxt == '0) begin
            dir_nxt = DIR_UP;
        end
    end

    assign period_evt = tick && !clr && (cmp_act != '0) && (cnt != '0) && (cnt_nxt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovie    <= 1'b0;
            en      <= 1'b0;
            mode    <= 1'b0;
            ovif    <= 1'b0;
            pscr    <= '0;
            psc     <= '0;
            pol     <= '0;
            cnt     <= '0;
            cmp_reg <= '0;
            dir     <= DIR_UP;
            for (int unsigned i = 0; i < CHN_NUM; i++) begin
                cr_reg[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                case (idx)
                    IDX_CTRL: begin
                        ovie <= pwdata[0];
                        en   <= pwdata[1];
                        mode <= pwdata[3];
                    end
                    IDX_PSCR: pscr    <= pwdata[PSCR_WIDTH-1:0];
                    IDX_CMP:  cmp_reg <= pwdata[CNT_WIDTH-1:0];
                    IDX_POL:  pol     <= pwdata[CHN_NUM-1:0];
                    default: begin
                        for (int unsigned i = 0; i < CHN_NUM; i++) begin
                            if (idx == IDX_CR0 + 5'(i)) begin
                                cr_reg[i] <= pwdata[CNT_WIDTH-1:0];
                            end
                        end
                    end
                endcase
            end

            if (clr) begin
                psc <= '0;
                cnt <= '0;
                dir <= DIR_UP;
            end else if (tick) begin
                psc <= '0;
                cnt <= cnt_nxt;
                dir <= dir_nxt;
            end else if (en) begin
                psc <= psc + 1'b1;
            end

            // Set has priority over a coincident software clear.
            if (period_evt && ovie) begin
                ovif <= 1'b1;
            end else if (stat_clr) begin
                ovif <= 1'b0;
            end
        end
    end

`ifdef PWM_SHADOW_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_act <= '0;
            for (int unsigned i = 0; i < CHN_NUM; i++) begin
                cr_act[i] <= '0;
            end
        end else if (period_evt || clr || !en) begin
            cmp_act <= cmp_reg;
            for (int unsigned i = 0; i < CHN_NUM; i++) begin
                cr_act[i] <= cr_reg[i];
            end
        end
    end
`else
    always_comb begin
        cmp_act = cmp_reg;
        for (int unsigned i = 0; i < CHN_NUM; i++) begin
            cr_act[i] = cr_reg[i];
        end
    end
`endif

    always_comb begin
        active = '0;
        for (int unsigned i = 0; i < CHN_NUM; i++) begin
            active[i] = en && (cmp_act != '0) && (cnt >= cr_act[i]);
        end
    end

    assign pwm_o = active ^ pol;

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (idx)
                IDX_CTRL: prdata[3:0]              = {mode, 1'b0, en, ovie};
                IDX_PSCR: prdata[PSCR_WIDTH-1:0]   = pscr;
                IDX_CMP:  prdata[CNT_WIDTH-1:0]    = cmp_reg;
                IDX_STAT: prdata[0]                = ovif;
                IDX_POL:  prdata[CHN_NUM-1:0]      = pol;
                default: begin
                    for (int unsigned i = 0; i < CHN_NUM; i++) begin
                        if (idx == IDX_CR0 + 5'(i)) begin
                            prdata[CNT_WIDTH-1:0] = cr_reg[i];
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_multi_core.sv
// Scoreboard bench for pwm_multi_core: stimulus queues expected reads/pin states, a negedge monitor checks them.
module tb_pwm_multi_core;
    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_PSCR = 8'h04;
    localparam logic [7:0] A_CMP  = 8'h08;
    localparam logic [7:0] A_STAT = 8'h0C;
    localparam logic [7:0] A_POL  = 8'h10;
    localparam logic [7:0] A_CR0  = 8'h20;
    localparam logic [7:0] A_CR1  = 8'h24;
    localparam logic [7:0] A_CR2  = 8'h28;
    localparam logic [7:0] A_CR3  = 8'h2C;
    localparam logic [31:0] IRQ   = 32'h10;
`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  pwm;
    logic        irq;
    logic        probe = 1'b0;

    item_t rd_q[$];
    item_t pin_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    pwm_multi_core #(.CHN_NUM(4), .CNT_WIDTH(16), .PSCR_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .pwm_o(pwm), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        item_t       it;
        logic [31:0] pins;
        if (psel && penable && !pwrite) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: got %h required no read", prdata);
            end else begin
                it = rd_q.pop_front();
                if (prdata !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h required %h", it.name, prdata, it.exp);
                end
            end
        end else if (probe) begin
            n_cmp++;
            if (prdata !== 32'h0 || pready !== 1'b1 || pslverr !== 1'b0) begin
                n_err++;
                $display("FAIL idle_bus: got prdata=%h pready=%b pslverr=%b required 0/1/0",
                         prdata, pready, pslverr);
            end
        end
        if (probe) begin
            n_cmp++;
            pins = 32'({irq, pwm});
            if (pin_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_probe: got %h required none", pins);
            end else begin
                it = pin_q.pop_front();
                if ((pins & it.mask) !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h required %h", it.name, pins & it.mask, it.exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [31:0] e, input string n);
        item_t it;
        it = '{n, e, 32'hFFFF_FFFF};
        rd_q.push_back(it);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic expect_pins(input string n, input logic [31:0] m, input logic [31:0] e);
        item_t it;
        it = '{n, e & m, m};
        pin_q.push_back(it);
        probe = 1'b1;
        @(posedge clk); #1 probe = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and register map
        expect_pins("reset_pins", 32'h1F, 32'h0);
        apb_read(A_CTRL, 32'h0, "rst_ctrl");
        apb_read(A_PSCR, 32'h0, "rst_pscr");
        apb_read(A_CMP,  32'h0, "rst_cmp");
        apb_read(A_STAT, 32'h0, "rst_stat");
        apb_read(A_POL,  32'h0, "rst_pol");
        apb_read(A_CR0,  32'h0, "rst_cr0");
        apb_read(8'h14,  32'h0, "unmapped_rd");
        apb_write(A_PSCR, 32'h0000_1234);
        apb_read(A_PSCR, 32'h0000_1234, "pscr_rw");
        apb_write(A_POL, 32'hFFFF_FFFF);
        apb_read(A_POL, 32'h0000_000F, "pol_width");
        apb_write(A_CR1, 32'hFFFF_ABCD);
        apb_read(A_CR1, 32'h0000_ABCD, "cr1_width");
        apb_write(A_CMP, 32'h0001_2345);
        apb_read(A_CMP, 32'h0000_2345, "cmp_width");
        apb_write(8'h18, 32'hFFFF_FFFF);
        apb_read(8'h18, 32'h0, "unmapped_wr");
        apb_write(8'h3C, 32'h0000_0055);
        apb_read(8'h3C, 32'h0, "cr_oob");
        apb_read(A_CR3, 32'h0, "cr3_no_alias");
        apb_write(A_CTRL, 32'h0000_000F);
        apb_read(A_CTRL, 32'h0000_000B, "ctrl_clr_reads0");
        apb_write(A_CTRL, 32'h4);
        apb_write(A_PSCR, 32'h0);
        apb_write(A_POL, 32'h0);

        // Edge run: CMP=10, CR0=4, one count per cycle
        apb_write(A_CMP, 32'd10);
        apb_write(A_CR0, 32'd4);
        apb_write(A_CTRL, 32'h2);
        for (int k = 0; k < 20; k++) begin
            e = ((k % 10) >= 4) ? 32'h1 : 32'h0;
            expect_pins($sformatf("edge_k%0d", k), 32'h11, e);
        end
        // Mid-period duty change
        apb_write(A_CR0, 32'd8);
        for (int k = 22; k < 40; k++) begin
            if (SHADOW && k < 30) e = ((k % 10) >= 4) ? 32'h1 : 32'h0;
            else                  e = ((k % 10) >= 8) ? 32'h1 : 32'h0;
            expect_pins($sformatf("cr_update_k%0d", k), 32'h11, e);
        end
        apb_write(A_CTRL, 32'h0);

        // Center run: PSCR=1, CMP=4, CR1=2, OVIE on to expose the period event
        apb_write(A_CTRL, 32'h4);
        apb_write(A_PSCR, 32'd1);
        apb_write(A_CMP, 32'd4);
        apb_write(A_CR1, 32'd2);
        apb_write(A_CTRL, 32'hB);
        for (int k = 0; k < 32; k++) begin
            e = (seq[(k / 2) % 8] >= 2) ? 32'h2 : 32'h0;
            if (k >= 16) e = e | IRQ;
            expect_pins($sformatf("center_k%0d", k), 32'h12, e);
        end
        apb_write(A_CTRL, 32'h4);
        apb_write(A_STAT, 32'h1);

        // Interrupt: CMP=5, PSCR=0
        apb_write(A_PSCR, 32'd0);
        apb_write(A_CMP, 32'd5);
        apb_write(A_CTRL, 32'h3);
        for (int k = 0; k < 6; k++) begin
            expect_pins($sformatf("irq_rise_k%0d", k), IRQ, (k >= 5) ? IRQ : 32'h0);
        end
        apb_read(A_STAT, 32'h1, "stat_set");
        expect_pins("irq_after_read", IRQ, IRQ);
        apb_write(A_STAT, 32'h1);
        expect_pins("irq_cleared", IRQ, 32'h0);
        expect_pins("irq_still_clear", IRQ, 32'h0);
        apb_write(A_STAT, 32'h1);
        expect_pins("irq_set_beats_clear", IRQ, IRQ);
        apb_write(A_CTRL, 32'h4);
        apb_write(A_STAT, 32'h1);

        // CMP=0: outputs follow POL, no events
        apb_write(A_CMP, 32'd0);
        apb_write(A_POL, 32'h5);
        apb_write(A_CTRL, 32'h3);
        for (int k = 0; k < 4; k++) begin
            expect_pins($sformatf("cmp0_k%0d", k), 32'h1F, 32'h05);
        end
        apb_write(A_CTRL, 32'h4);
        apb_write(A_POL, 32'h0);

        // CR2=0 constant active, CR3=11 > max constant inactive
        apb_write(A_CMP, 32'd10);
        apb_write(A_CR0, 32'd1);
        apb_write(A_CR2, 32'd0);
        apb_write(A_CR3, 32'd11);
        apb_write(A_CTRL, 32'h2);
        for (int k = 0; k < 12; k++) begin
            expect_pins($sformatf("cr_bounds_k%0d", k), 32'hC, 32'h4);
        end
        // CLR while every cycle ticks: counter restarts at 0 (pwm0 low only at 0)
        apb_write(A_CTRL, 32'h6);
        for (int k = 14; k < 25; k++) begin
            e = (((k - 14) % 10) != 0) ? 32'h1 : 32'h0;
            expect_pins($sformatf("clr_tick_k%0d", k), 32'h1, e);
        end

        // Reset mid-period with OVIF set
        apb_write(A_POL, 32'h2);
        apb_write(A_CTRL, 32'h3);
        repeat (10) @(posedge clk);
        #1;
        expect_pins("irq_before_rst", IRQ, IRQ);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expect_pins("post_rst_pins", 32'h1F, 32'h0);
        apb_read(A_CTRL, 32'h0, "post_rst_ctrl");
        apb_read(A_PSCR, 32'h0, "post_rst_pscr");
        apb_read(A_CMP,  32'h0, "post_rst_cmp");
        apb_read(A_STAT, 32'h0, "post_rst_stat");
        apb_read(A_POL,  32'h0, "post_rst_pol");
        apb_read(A_CR0,  32'h0, "post_rst_cr0");
        apb_read(A_CR3,  32'h0, "post_rst_cr3");
        expect_pins("post_rst_idle", 32'h1F, 32'h0);

        @(posedge clk);
        #1;
        n_cmp++;
        if (rd_q.size() != 0 || pin_q.size() != 0) begin
            n_err++;
            $display("FAIL queues_drained: got %0d/%0d required 0/0", rd_q.size(), pin_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
